// File: rtl/lock_rst_pkg.sv
// Shared types and default constants for the PLL lock reset generator.
// Holds the FSM state encoding and the counter-width helper.
package lock_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLLRST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_HOLD
  } state_e;

  localparam int unsigned DEF_SYNC_STAGES    = 2;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65536;
  localparam int unsigned DEF_ARST_CYCLES    = 16;
  localparam int unsigned DEF_HOLD_CYCLES    = 16;
  localparam int unsigned DEF_CNT_W          = 8;

  // clog2 of the largest interval; never narrower than one bit.
  function automatic int unsigned cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned d
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) > 0) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchronizer with synchronous active-low clear.
// Ports: clk_i clock, clr_ni clear, d_i async input, q_o synced output.
module sync_ff #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic clr_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] ff_q;

  // Shift d_i in at bit 0; the oldest sample leaves from the top.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      ff_q <= '0;
    end else begin
      ff_q <= N'({ff_q, d_i});
    end
  end

  assign q_o = ff_q[N-1];

endmodule

// File: rtl/lock_rst_gen.sv
// PLL lock supervisor: pulses pll_areset, waits for a stable lock,
// then releases rst_out_n. Ports: clk, rst (sync, active low),
// locked (async), pll_areset, rst_out_n, loss_cnt, retry_cnt.
module lock_rst_gen
  import lock_rst_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned ARST_CYCLES    = DEF_ARST_CYCLES,
  parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             locked,
  output logic             pll_areset,
  output logic             rst_out_n,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] retry_cnt
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES,
                                         TIMEOUT_CYCLES,
                                         ARST_CYCLES,
                                         HOLD_CYCLES);

  localparam logic [CW-1:0] ARST_LAST = CW'(ARST_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  logic             lk_s;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             pa_q;
  logic             ron_q;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  sync_ff #(
    .N(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk),
    .clr_ni(rst),
    .d_i   (locked),
    .q_o   (lk_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    loss_d  = loss_q;
    retry_d = retry_q;
    unique case (state_q)
      ST_PLLRST: begin
        if (cnt_q == ARST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lk_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_PLLRST;
          retry_d = sat_inc(retry_q);
        end
      end
      ST_STABLE: begin
        if (!lk_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lk_s) begin
          state_d = ST_HOLD;
          loss_d  = sat_inc(loss_q);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
      end
      default: state_d = ST_PLLRST;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they are
  // registered yet track the state without extra lag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_PLLRST;
      cnt_q   <= '0;
      loss_q  <= '0;
      retry_q <= '0;
      pa_q    <= 1'b1;
      ron_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
      retry_q <= retry_d;
      pa_q    <= (state_d == ST_PLLRST);
      ron_q   <= (state_d == ST_RUN);
    end
  end

  assign pll_areset = pa_q;
  assign rst_out_n  = ron_q;
  assign loss_cnt   = loss_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_lock_rst_gen.sv
// Scoreboard bench for lock_rst_gen: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_lock_rst_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_areset;
  logic       rst_out_n;
  logic [3:0] loss_cnt;
  logic [3:0] retry_cnt;

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;

  typedef struct {
    int         c;
    string      nm;
    logic       pa;
    logic       ron;
    logic [3:0] loss;
    logic [3:0] retry;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  localparam int R = 3;
  localparam int P = R + 25;
  localparam int Q = P + 20;
  localparam int S = Q + 24;
  localparam int U = S + 589;

  lock_rst_gen #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .TIMEOUT_CYCLES(32),
    .ARST_CYCLES   (4),
    .HOLD_CYCLES   (4),
    .CNT_W         (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .pll_areset(pll_areset),
    .rst_out_n (rst_out_n),
    .loss_cnt  (loss_cnt),
    .retry_cnt (retry_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_to(input int c);
    while (cyc != c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input string n,
                      input logic pa, input logic ron,
                      input logic [3:0] lo, input logic [3:0] rt);
    exp_t x;
    x.c = c;
    x.nm = n;
    x.pa = pa;
    x.ron = ron;
    x.loss = lo;
    x.retry = rt;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      nchk++;
      if (e.c != cyc || pll_areset !== e.pa ||
          rst_out_n !== e.ron || loss_cnt !== e.loss ||
          retry_cnt !== e.retry) begin
        nfail++;
        $display("FAIL %s cyc=%0d/%0d got pa=%b ron=%b loss=%0d retry=%0d exp pa=%b ron=%b loss=%0d retry=%0d",
                 e.nm, cyc, e.c, pll_areset, rst_out_n,
                 loss_cnt, retry_cnt, e.pa, e.ron, e.loss, e.retry);
      end
    end
  end

  initial begin
    int rp;
    int rk;
    rst = 1'b0;
    locked = 1'b0;

    // Reset, areset pulse, first lock.
    wait_to(R);
    push(R, "reset_vals", 1, 0, 0, 0);
    push(R + 3, "arst_last", 1, 0, 0, 0);
    push(R + 4, "arst_done", 0, 0, 0, 0);
    push(R + 20, "pre_run", 0, 0, 0, 0);
    push(R + 21, "run_entry", 0, 1, 0, 0);
    rst = 1'b1;
    wait_to(R + 10);
    locked = 1'b1;

    // One-cycle lock drop in RUN.
    wait_to(P);
    push(P + 2, "loss_pre", 0, 1, 0, 0);
    push(P + 3, "loss_hold", 0, 0, 1, 0);
    push(P + 6, "hold_min", 0, 0, 1, 0);
    push(P + 15, "rerun_pre", 0, 0, 1, 0);
    push(P + 16, "rerun", 0, 1, 1, 0);
    locked = 1'b0;
    wait_to(P + 1);
    locked = 1'b1;

    // Reset in RUN, then a glitch at STABLE count 5.
    wait_to(Q);
    push(Q, "run_before_rst", 0, 1, 1, 0);
    push(Q + 1, "midrun_rst", 1, 0, 0, 0);
    push(Q + 4, "rearst_last", 1, 0, 0, 0);
    push(Q + 5, "rearst_done", 0, 0, 0, 0);
    push(Q + 14, "glitch_norun", 0, 0, 0, 0);
    push(Q + 20, "glitch_pre", 0, 0, 0, 0);
    push(Q + 21, "glitch_run", 0, 1, 0, 0);
    rst = 1'b0;
    wait_to(Q + 1);
    rst = 1'b1;
    wait_to(Q + 9);
    locked = 1'b0;
    wait_to(Q + 10);
    locked = 1'b1;

    // Permanent loss: hold, then periodic timeouts.
    wait_to(S);
    push(S + 2, "drop_pre", 0, 1, 0, 0);
    push(S + 3, "drop_hold", 0, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      rp = (k - 1 > 15) ? 15 : k - 1;
      rk = (k > 15) ? 15 : k;
      push(S + 2 + 36 * k, "tmo_pre", 0, 0, 1, 4'(rp));
      push(S + 3 + 36 * k, "tmo_arst", 1, 0, 1, 4'(rk));
      push(S + 6 + 36 * k, "tmo_arst_end", 1, 0, 1, 4'(rk));
      push(S + 7 + 36 * k, "tmo_wait", 0, 0, 1, 4'(rk));
    end
    locked = 1'b0;

    // Lock arriving on the final timeout cycle.
    wait_to(U);
    push(U + 1, "rst2_vals", 1, 0, 0, 0);
    push(U + 4, "rst2_arst", 1, 0, 0, 0);
    push(U + 5, "rst2_wait", 0, 0, 0, 0);
    push(U + 36, "tmo_edge", 0, 0, 0, 0);
    push(U + 37, "lock_wins", 0, 0, 0, 0);
    push(U + 44, "lock_wins_pre", 0, 0, 0, 0);
    push(U + 45, "lock_wins_run", 0, 1, 0, 0);
    rst = 1'b0;
    wait_to(U + 1);
    rst = 1'b1;
    wait_to(U + 34);
    locked = 1'b1;

    wait_to(U + 50);
    nchk++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL sb_drain left=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/lock_rst_gen.md
LOCK_RST_GEN -- requirements
Module: lock_rst_gen

Interface
REQ-001 Parameter SYNC_STAGES, default 2: flop count of the synchronizer on the locked input.
REQ-002 Parameter STABLE_CYCLES, default 1024: cycles locked must stay high before downstream reset is released.
REQ-003 Parameter TIMEOUT_CYCLES, default 65536: cycles allowed in WAIT_LOCK before the PLL is re-reset.
REQ-004 Parameter ARST_CYCLES, default 16: width of the pll_areset pulse, in cycles.
REQ-005 Parameter HOLD_CYCLES, default 16: minimum rst_out_n low time after a lock loss.
REQ-006 Parameter CNT_W, default 8: width of loss_cnt and retry_cnt.
REQ-007 clk  input  1  single system clock; all logic on rising edge.
REQ-008 rst  input  1  synchronous, active-low reset.
REQ-009 locked  input  1  PLL lock flag, asynchronous to clk.
REQ-010 pll_areset  output  1  active-high reset request to the PLL.
REQ-011 rst_out_n  output  1  active-low synchronous reset for the downstream LED stages; 1 only in RUN.
REQ-012 loss_cnt  output  CNT_W  saturating count of lock losses seen in RUN.
REQ-013 retry_cnt  output  CNT_W  saturating count of lock timeouts.

Function
REQ-014 locked shall pass through SYNC_STAGES flops to form lk_s; the FSM shall use only lk_s.
REQ-015 FSM states: PLLRST, WAIT_LOCK, STABLE, RUN, HOLD; one shared cycle counter is cleared on every state change.
REQ-016 PLLRST: pll_areset=1 and lk_s ignored; after ARST_CYCLES cycles go to WAIT_LOCK.
REQ-017 WAIT_LOCK: lk_s=1 goes to STABLE; otherwise, when the counter reaches TIMEOUT_CYCLES-1, go to PLLRST and increment retry_cnt.
REQ-018 WAIT_LOCK, lk_s=1 in the same cycle as the timeout: the lock wins, so go to STABLE with no retry increment.
REQ-019 STABLE: any lk_s=0 cycle returns to WAIT_LOCK with a fresh timeout; reaching STABLE_CYCLES-1 with lk_s=1 goes to RUN.
REQ-020 Latency: with lk_s first high in cycle t and then continuously high, rst_out_n rises at edge t+STABLE_CYCLES+1.
REQ-021 RUN: lk_s=0 goes to HOLD and increments loss_cnt; rst_out_n is low from the next edge (1-cycle latency).
REQ-022 HOLD: rst_out_n=0 and lk_s ignored for HOLD_CYCLES cycles, then go to WAIT_LOCK.
REQ-023 loss_cnt and retry_cnt shall saturate at all-ones and never wrap.
REQ-024 All outputs shall be registered, with no combinational path from locked to any output.
REQ-025 pll_areset shall be 1 only in PLLRST; rst_out_n shall be 1 only in RUN.

Reset
REQ-026 With rst=0 sampled at an edge: state=PLLRST, counter=0, sync flops=0, pll_areset=1, rst_out_n=0, loss_cnt=0, retry_cnt=0.
REQ-027 rst asserted mid-operation, in any state including RUN, shall force the REQ-026 values at the next edge.
REQ-028 After rst is released, a full ARST_CYCLES pulse shall be issued before lock is evaluated.

Structure
REQ-029 Package lock_rst_pkg shall hold the state enumeration and the default parameter constants.
REQ-030 One sub-module, sync_ff: an N-stage single-bit synchronizer with synchronous active-low clear, instantiated once.
REQ-031 Counter width shall be the clog2 of the largest of STABLE_CYCLES, TIMEOUT_CYCLES, ARST_CYCLES and HOLD_CYCLES.

Verification
Bench parameters: SYNC_STAGES=2, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, ARST_CYCLES=4, HOLD_CYCLES=4, CNT_W=4.
REQ-032 Release rst; raise locked at cycle 10 and hold it -> pll_areset high for cycles 1-4; rst_out_n rises 2+8+1 cycles after locked is sampled.
REQ-033 Hold locked low -> pll_areset pulses 4 cycles every 36 cycles; retry_cnt counts 1..15 and holds at 15.
REQ-034 In RUN, drop locked for 1 cycle -> rst_out_n low 3 cycles later and stays low at least 4 cycles; loss_cnt=1; re-release after 8 more stable cycles.
REQ-035 In STABLE, glitch locked low at count 5 -> no RUN entry; the STABLE count restarts from 0.
REQ-036 Assert rst for 1 cycle while in RUN -> all REQ-026 values on the next edge; the PLLRST pulse repeats.
REQ-037 Raise locked so lk_s reaches 1 exactly on timeout cycle 31 -> state STABLE and retry_cnt unchanged.
